uart_tx_scheduler: RTL and testbench
====================================

Name: uart_tx_scheduler

Overview:
- Shares the single RS485 UART transmitter between NREQ frame sources.
- Round-robin arbitration; drives the transmitter's RQ/cycle/data inputs; uses the transmitter's dirRX line as its busy indicator.
- Completion is reported back to the winning requester as a one-cycle pulse.
- Sits between the per-source frame buffers and the UART TX instance, on the same clk.

Parameters:
- NREQ, 4, number of requesters (2..8).
- GAP_CYCLES, 8, cycles RQ is held low after a frame before the next arbitration; minimum 4, covers the TX's 2-flop RQ sync and its release state.
- TIMEOUT_CYCLES, 16'd4000, watchdog limit per frame phase (optional feature only).

Ports:
- clk  in  1  clock, same domain as the UART TX.
- reset  in  1  asynchronous, active-low.
- req  in  NREQ  level requests; req[i] held high until done[i] or err.
- data_in  in  NREQ*8  byte from each requester's buffer; slice i = data_in[8*i+7:8*i].
- tx_addr  in  5  byte index from the UART TX; forwarded unchanged on rd_addr.
- tx_dirrx  in  1  UART TX dirRX: high while the transmitter owns the bus.
- rd_addr  out  5  byte address to the requester buffers (= tx_addr).
- tx_data  out  8  data_in slice of the granted requester; 8'h00 when no grant.
- tx_rq  out  1  transfer request to the UART TX.
- tx_cycle  out  5  frame sequence number presented to the UART TX.
- grant  out  NREQ  one-hot owner; all-zero when idle.
- done  out  NREQ  one-cycle pulse on the owner's bit at frame completion.
- busy  out  1  high in every state except IDLE.
- err  out  1  one-cycle watchdog pulse; tied 0 without the optional feature.

Behaviour:
- Reset (async, active-low): state=IDLE; all outputs are 0 (tx_rq, tx_cycle, grant, done, busy, err). Round-robin pointer is 0; gap counter is 0.
- IDLE: if any req is set, go to ARB on the next edge.
- ARB (1 cycle):
  - Search for a set req starting at the pointer index, wrapping NREQ-1 -> 0.
  - Register grant one-hot. Set pointer = winner+1 mod NREQ.
  - Go to START. If req dropped to zero meanwhile, return to IDLE.
- START:
  - tx_rq=1 from the first START cycle.
  - Wait for tx_dirrx rising (sample 0 then 1), then go to RUN.
- RUN:
  - tx_rq stays 1. Wait for tx_dirrx falling, then go to RELEASE.
  - On that edge: pulse done[winner] for 1 cycle; tx_cycle <= tx_cycle+1, wrapping 31 -> 0.
- RELEASE:
  - tx_rq=0; grant cleared on entry.
  - Count GAP_CYCLES cycles, then go to IDLE.
- tx_data is combinational from grant and data_in, with zero added latency from tx_addr/grant. rd_addr = tx_addr combinationally.
- A requester dropping req while granted does not abort the frame; the frame completes and done still pulses.
- Simultaneous requests: only the winner is served; the others stay pending and are re-arbitrated after RELEASE. Each of NREQ continuous requesters is served once per NREQ frames.
- tx_dirrx activity in IDLE/ARB/RELEASE is ignored.
- busy = (state != IDLE).

Optional Feature:
- UART_SCHED_WATCHDOG_EN defined:
  - A 16-bit counter clears on entry to START and to RUN, and increments each cycle in those states.
  - On reaching TIMEOUT_CYCLES: err pulses 1 cycle, no done pulse, tx_cycle is unchanged, state goes to RELEASE (tx_rq dropped, grant cleared). The pointer still advances past the failed requester.
- Undefined: no counter; START/RUN wait indefinitely; err is constant 0.

Test Plan:
- req=4'b0001, model TX raises dirRX 3 cycles after tx_rq and drops it 200 cycles later -> grant=0001, one done[0] pulse, tx_cycle 0->1, tx_rq low exactly GAP_CYCLES=8 cycles before IDLE.
- req=4'b1111 held for 5 frames -> grant sequence 0001,0010,0100,1000,0001; tx_cycle ends at 5.
- Grant to requester 2 with data_in slice 2 = 8'hA5 and tx_addr=5'd7 -> tx_data=8'hA5 and rd_addr=7 in the same cycle.
- tx_cycle at 31 with one more frame -> wraps to 0; done still pulses.
- Reset asserted in RUN mid-frame -> tx_rq, grant, busy, tx_cycle all 0 immediately (async); after release, req=0010 re-arbitrates from pointer 0.
- With UART_SCHED_WATCHDOG_EN, TIMEOUT_CYCLES=100, dirRX never rises -> err pulses at START cycle 100, no done, tx_rq low, tx_cycle unchanged, next grant goes to the next requester.

Source files
------------

// File: rtl/uart_tx_scheduler_if.sv
// Requester/transmitter bus of the UART TX scheduler.
// master: the scheduler. slave: requester buffers plus the UART TX instance.
interface uart_tx_scheduler_if #(
   parameter int unsigned NREQ = 4
);
   localparam int unsigned DW = NREQ * 8;

   logic [NREQ-1:0] req;
   logic [DW-1:0]   data_in;
   logic [4:0]      tx_addr;
   logic            tx_dirrx;
   logic [4:0]      rd_addr;
   logic [7:0]      tx_data;
   logic            tx_rq;
   logic [4:0]      tx_cycle;
   logic [NREQ-1:0] grant;
   logic [NREQ-1:0] done;
   logic            busy;
   logic            err;

   modport master (
      input  req, data_in, tx_addr, tx_dirrx,
      output rd_addr, tx_data, tx_rq, tx_cycle, grant, done, busy, err
   );

   modport slave (
      output req, data_in, tx_addr, tx_dirrx,
      input  rd_addr, tx_data, tx_rq, tx_cycle, grant, done, busy, err
   );
endinterface

// File: rtl/uart_tx_scheduler.sv
// Round-robin scheduler sharing one RS485 UART transmitter between NREQ sources.
// Optional frame watchdog: define UART_SCHED_WATCHDOG_EN (otherwise err is tied 0).
module uart_tx_scheduler #(
   parameter int unsigned NREQ           = 4,
   parameter int unsigned GAP_CYCLES     = 8,
   parameter logic [15:0] TIMEOUT_CYCLES = 16'd4000
) (
   input logic                 clk,
   input logic                 reset,
   uart_tx_scheduler_if.master bus
);
   localparam int unsigned PTR_W = (NREQ > 1) ? $clog2(NREQ) : 1;
   localparam int unsigned GAP_W = $clog2(GAP_CYCLES + 1);
   localparam int unsigned CYC_W = 5;

   typedef enum logic [2:0] {IDLE, ARB, START, RUN, RELEASE} state_t;

   state_t            state, state_n;
   logic [PTR_W-1:0]  ptr_q, ptr_n;
   logic [PTR_W-1:0]  gidx_q, gidx_n;
   logic [PTR_W-1:0]  win_idx, win_next;
   logic [PTR_W:0]    cand;
   logic              win_found;
   logic [NREQ-1:0]   grant_q, grant_n;
   logic [NREQ-1:0]   done_q, done_n;
   logic              tx_rq_q, tx_rq_n;
   logic              busy_q, busy_n;
   logic [CYC_W-1:0]  cycle_q, cycle_n;
   logic [GAP_W-1:0]  gap_q, gap_n;
   logic              dirrx_q;
   logic              dirrx_rise, dirrx_fall;
`ifdef UART_SCHED_WATCHDOG_EN
   logic [15:0]       wd_q, wd_n;
   logic              err_q, err_n;
   logic              wd_expired;
`else
   logic              unused_timeout;
`endif

   // Edge detection on the transmitter's bus-ownership line.
   assign dirrx_rise = bus.tx_dirrx & ~dirrx_q;
   assign dirrx_fall = ~bus.tx_dirrx & dirrx_q;

   // First set request at or after the pointer, wrapping NREQ-1 -> 0.
   always_comb begin
      win_found = 1'b0;
      win_idx   = '0;
      cand      = '0;
      for (int k = 0; k < int'(NREQ); k++) begin
         cand = (PTR_W+1)'(ptr_q) + (PTR_W+1)'(k);
         if (cand >= (PTR_W+1)'(NREQ)) cand = cand - (PTR_W+1)'(NREQ);
         if (!win_found && bus.req[cand[PTR_W-1:0]]) begin
            win_found = 1'b1;
            win_idx   = cand[PTR_W-1:0];
         end
      end
      win_next = (win_idx == PTR_W'(NREQ - 1)) ? '0 : win_idx + PTR_W'(1);
   end

`ifdef UART_SCHED_WATCHDOG_EN
   assign wd_expired = (wd_q == TIMEOUT_CYCLES - 16'd1);
`endif

   // Next-state and next-output logic.
   always_comb begin
      state_n = state;
      ptr_n   = ptr_q;
      gidx_n  = gidx_q;
      grant_n = grant_q;
      done_n  = '0;
      cycle_n = cycle_q;
      gap_n   = gap_q;
`ifdef UART_SCHED_WATCHDOG_EN
      wd_n    = wd_q;
      err_n   = 1'b0;
`endif
      case (state)
         IDLE: begin
            if (|bus.req) state_n = ARB;
         end
         ARB: begin
            if (win_found) begin
               state_n = START;
               grant_n = NREQ'(1) << win_idx;
               gidx_n  = win_idx;
               ptr_n   = win_next;
`ifdef UART_SCHED_WATCHDOG_EN
               wd_n    = '0;
`endif
            end else begin
               state_n = IDLE;
            end
         end
         START: begin
            if (dirrx_rise) begin
               state_n = RUN;
`ifdef UART_SCHED_WATCHDOG_EN
               wd_n    = '0;
            end else if (wd_expired) begin
               state_n = RELEASE;
               grant_n = '0;
               gap_n   = '0;
               err_n   = 1'b1;
            end else begin
               wd_n    = wd_q + 16'd1;
`endif
            end
         end
         RUN: begin
            if (dirrx_fall) begin
               state_n = RELEASE;
               done_n  = grant_q;
               cycle_n = cycle_q + CYC_W'(1);
               grant_n = '0;
               gap_n   = '0;
`ifdef UART_SCHED_WATCHDOG_EN
            end else if (wd_expired) begin
               state_n = RELEASE;
               grant_n = '0;
               gap_n   = '0;
               err_n   = 1'b1;
            end else begin
               wd_n    = wd_q + 16'd1;
`endif
            end
         end
         RELEASE: begin
            if (gap_q == GAP_W'(GAP_CYCLES - 1)) state_n = IDLE;
            else                                 gap_n   = gap_q + GAP_W'(1);
         end
         default: state_n = IDLE;
      endcase
      tx_rq_n = (state_n == START) || (state_n == RUN);
      busy_n  = (state_n != IDLE);
   end

   // State and registered outputs.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state   <= IDLE;
         ptr_q   <= '0;
         gidx_q  <= '0;
         grant_q <= '0;
         done_q  <= '0;
         tx_rq_q <= 1'b0;
         busy_q  <= 1'b0;
         cycle_q <= '0;
         gap_q   <= '0;
         dirrx_q <= 1'b0;
`ifdef UART_SCHED_WATCHDOG_EN
         wd_q    <= '0;
         err_q   <= 1'b0;
`endif
      end else begin
         state   <= state_n;
         ptr_q   <= ptr_n;
         gidx_q  <= gidx_n;
         grant_q <= grant_n;
         done_q  <= done_n;
         tx_rq_q <= tx_rq_n;
         busy_q  <= busy_n;
         cycle_q <= cycle_n;
         gap_q   <= gap_n;
         dirrx_q <= bus.tx_dirrx;
`ifdef UART_SCHED_WATCHDOG_EN
         wd_q    <= wd_n;
         err_q   <= err_n;
`endif
      end
   end

   // Data and address paths are pass-through with no added latency.
   assign bus.rd_addr  = bus.tx_addr;
   assign bus.tx_data  = (|grant_q) ? bus.data_in[{gidx_q, 3'b000} +: 8] : 8'h00;
   assign bus.tx_rq    = tx_rq_q;
   assign bus.tx_cycle = cycle_q;
   assign bus.grant    = grant_q;
   assign bus.done     = done_q;
   assign bus.busy     = busy_q;
`ifdef UART_SCHED_WATCHDOG_EN
   assign bus.err      = err_q;
`else
   assign bus.err      = 1'b0;
   assign unused_timeout = ^TIMEOUT_CYCLES;
`endif
endmodule

// File: tb/tb_uart_tx_scheduler.sv
// Directed bench for uart_tx_scheduler with a simple UART TX dirRX model.
module tb_uart_tx_scheduler;
   localparam int unsigned NREQ = 4;
   localparam int unsigned GAP  = 8;

   logic clk;
   logic reset;
   int   n_tests;
   int   n_fail;
   logic model_en;
   int   model_len;
   int   m_st;
   int   m_cnt;

   uart_tx_scheduler_if #(.NREQ(NREQ)) bus ();

   uart_tx_scheduler #(
      .NREQ(NREQ), .GAP_CYCLES(GAP), .TIMEOUT_CYCLES(16'd100)
   ) dut (
      .clk(clk), .reset(reset), .bus(bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // TX model: raises dirRX ~3 cycles after tx_rq, holds it model_len cycles.
   always @(negedge clk) begin
      if (!model_en) begin
         m_st <= 0; m_cnt <= 0; bus.tx_dirrx <= 1'b0;
      end else begin
         case (m_st)
            0: if (bus.tx_rq) begin m_st <= 1; m_cnt <= 1; end
            1: if (m_cnt >= 3) begin bus.tx_dirrx <= 1'b1; m_st <= 2; m_cnt <= 1; end
               else m_cnt <= m_cnt + 1;
            2: if (m_cnt >= model_len) begin bus.tx_dirrx <= 1'b0; m_st <= 3; end
               else m_cnt <= m_cnt + 1;
            3: if (!bus.tx_rq) m_st <= 0;
            default: m_st <= 0;
         endcase
      end
   end

   task automatic tick();
      @(posedge clk); #1;
   endtask

   task automatic do_reset();
      @(negedge clk);
      reset = 1'b0; model_en = 1'b0; bus.req = '0;
      repeat (3) @(negedge clk);
      reset = 1'b1; model_en = 1'b1;
   endtask

   task automatic wait_grant(input int budget, output logic ok);
      ok = 1'b0;
      for (int i = 0; i < budget; i++) begin
         tick();
         if (bus.grant != '0) begin ok = 1'b1; break; end
      end
   endtask

   task automatic wait_done(input int budget, output logic ok);
      ok = 1'b0;
      for (int i = 0; i < budget; i++) begin
         tick();
         if (bus.done != '0) begin ok = 1'b1; break; end
      end
   endtask

   task automatic wait_idle(input int budget, output logic ok);
      ok = 1'b0;
      for (int i = 0; i < budget; i++) begin
         tick();
         if (!bus.busy) begin ok = 1'b1; break; end
      end
   endtask

   task automatic test_reset();
      reset = 1'b0; model_en = 1'b0; model_len = 10;
      bus.req = '0; bus.data_in = '0; bus.tx_addr = '0;
      repeat (3) @(negedge clk);
      #1;
      n_tests++; if (bus.tx_rq !== 1'b0)    begin n_fail++; $display("FAIL reset_tx_rq: got %b want 0", bus.tx_rq); end
      n_tests++; if (bus.tx_cycle !== 5'd0) begin n_fail++; $display("FAIL reset_tx_cycle: got %0d want 0", bus.tx_cycle); end
      n_tests++; if (bus.grant !== 4'b0000) begin n_fail++; $display("FAIL reset_grant: got %b want 0000", bus.grant); end
      n_tests++; if (bus.done !== 4'b0000)  begin n_fail++; $display("FAIL reset_done: got %b want 0000", bus.done); end
      n_tests++; if (bus.busy !== 1'b0)     begin n_fail++; $display("FAIL reset_busy: got %b want 0", bus.busy); end
      n_tests++; if (bus.err !== 1'b0)      begin n_fail++; $display("FAIL reset_err: got %b want 0", bus.err); end
      @(negedge clk);
      reset = 1'b1; model_en = 1'b1;
      tick();
      n_tests++; if (bus.busy !== 1'b0)     begin n_fail++; $display("FAIL idle_no_req_busy: got %b want 0", bus.busy); end
   endtask

   task automatic test_single();
      logic ok;
      int   lowcnt, dones;
      model_len = 200;
      @(negedge clk); bus.req = 4'b0001;
      wait_grant(10, ok);
      n_tests++; if (!ok) begin n_fail++; $display("FAIL single_grant_timeout: got none want grant"); end
      n_tests++; if (bus.grant !== 4'b0001) begin n_fail++; $display("FAIL single_grant: got %b want 0001", bus.grant); end
      n_tests++; if (bus.tx_rq !== 1'b1)    begin n_fail++; $display("FAIL single_rq_start: got %b want 1", bus.tx_rq); end
      wait_done(300, ok);
      n_tests++; if (!ok) begin n_fail++; $display("FAIL single_done_timeout: got none want done"); end
      n_tests++; if (bus.done !== 4'b0001)  begin n_fail++; $display("FAIL single_done: got %b want 0001", bus.done); end
      n_tests++; if (bus.tx_cycle !== 5'd1) begin n_fail++; $display("FAIL single_cycle: got %0d want 1", bus.tx_cycle); end
      n_tests++; if (bus.grant !== 4'b0000) begin n_fail++; $display("FAIL single_grant_clr: got %b want 0000", bus.grant); end
      lowcnt = (!bus.tx_rq && bus.busy) ? 1 : 0;
      dones  = 1;
      @(negedge clk); bus.req = '0;
      for (int i = 0; i < 20; i++) begin
         tick();
         if (bus.done != '0) dones++;
         if (!bus.busy) break;
         if (!bus.tx_rq) lowcnt++;
      end
      n_tests++; if (lowcnt != int'(GAP)) begin n_fail++; $display("FAIL single_gap: got %0d want %0d", lowcnt, GAP); end
      n_tests++; if (dones != 1)          begin n_fail++; $display("FAIL single_done_count: got %0d want 1", dones); end
      n_tests++; if (bus.busy !== 1'b0)   begin n_fail++; $display("FAIL single_idle: got busy %b want 0", bus.busy); end
   endtask

   task automatic test_round_robin();
      logic       ok;
      logic [3:0] exp_rr [5];
      exp_rr = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};
      do_reset();
      model_len = 6;
      @(negedge clk); bus.req = 4'b1111;
      for (int f = 0; f < 5; f++) begin
         wait_grant(20, ok);
         n_tests++; if (bus.grant !== exp_rr[f]) begin n_fail++; $display("FAIL rr_grant%0d: got %b want %b", f, bus.grant, exp_rr[f]); end
         wait_done(100, ok);
         n_tests++; if (bus.done !== exp_rr[f])  begin n_fail++; $display("FAIL rr_done%0d: got %b want %b", f, bus.done, exp_rr[f]); end
      end
      n_tests++; if (bus.tx_cycle !== 5'd5) begin n_fail++; $display("FAIL rr_cycle: got %0d want 5", bus.tx_cycle); end
      @(negedge clk); bus.req = '0;
      wait_idle(30, ok);
      n_tests++; if (!ok) begin n_fail++; $display("FAIL rr_idle_timeout: got busy want idle"); end
   endtask

   task automatic test_data_path();
      logic ok;
      do_reset();
      model_len = 10;
      @(negedge clk);
      bus.data_in = {8'h44, 8'hA5, 8'h22, 8'h11};
      bus.tx_addr = 5'd7;
      tick();
      n_tests++; if (bus.tx_data !== 8'h00) begin n_fail++; $display("FAIL data_nogrant: got %h want 00", bus.tx_data); end
      @(negedge clk); bus.req = 4'b0100;
      wait_grant(10, ok);
      n_tests++; if (bus.grant !== 4'b0100) begin n_fail++; $display("FAIL data_grant: got %b want 0100", bus.grant); end
      n_tests++; if (bus.tx_data !== 8'hA5) begin n_fail++; $display("FAIL data_slice2: got %h want a5", bus.tx_data); end
      n_tests++; if (bus.rd_addr !== 5'd7)  begin n_fail++; $display("FAIL data_rdaddr: got %0d want 7", bus.rd_addr); end
      @(negedge clk);
      bus.tx_addr = 5'd19;
      bus.data_in[23:16] = 8'h5A;
      #1;
      n_tests++; if (bus.tx_data !== 8'h5A) begin n_fail++; $display("FAIL data_samecycle: got %h want 5a", bus.tx_data); end
      n_tests++; if (bus.rd_addr !== 5'd19) begin n_fail++; $display("FAIL rdaddr_samecycle: got %0d want 19", bus.rd_addr); end
      wait_done(100, ok);
      n_tests++; if (bus.done !== 4'b0100)  begin n_fail++; $display("FAIL data_done: got %b want 0100", bus.done); end
      @(negedge clk); bus.req = '0;
      wait_idle(30, ok);
   endtask

   task automatic test_cycle_wrap();
      logic ok;
      do_reset();
      model_len = 2;
      @(negedge clk); bus.req = 4'b0001;
      for (int f = 0; f < 31; f++) begin
         wait_done(60, ok);
         if (!ok) break;
      end
      n_tests++; if (bus.tx_cycle !== 5'd31) begin n_fail++; $display("FAIL wrap_pre: got %0d want 31", bus.tx_cycle); end
      wait_done(60, ok);
      n_tests++; if (bus.done !== 4'b0001)   begin n_fail++; $display("FAIL wrap_done: got %b want 0001", bus.done); end
      n_tests++; if (bus.tx_cycle !== 5'd0)  begin n_fail++; $display("FAIL wrap_cycle: got %0d want 0", bus.tx_cycle); end
      @(negedge clk); bus.req = '0;
      wait_idle(30, ok);
   endtask

   task automatic test_reset_midframe();
      logic ok;
      do_reset();
      model_len = 50;
      @(negedge clk); bus.req = 4'b0010;
      wait_done(100, ok);
      n_tests++; if (bus.done !== 4'b0010) begin n_fail++; $display("FAIL mid_setup_done: got %b want 0010", bus.done); end
      @(negedge clk); bus.req = '0;
      wait_idle(30, ok);
      @(negedge clk); bus.req = 4'b0100;
      wait_grant(10, ok);
      n_tests++; if (bus.grant !== 4'b0100) begin n_fail++; $display("FAIL mid_grant: got %b want 0100", bus.grant); end
      for (int i = 0; i < 20; i++) begin
         tick();
         if (bus.tx_dirrx) break;
      end
      repeat (5) tick();
      n_tests++; if (bus.tx_cycle !== 5'd1) begin n_fail++; $display("FAIL mid_cycle_pre: got %0d want 1", bus.tx_cycle); end
      @(negedge clk);
      reset = 1'b0; model_en = 1'b0;
      #1;
      n_tests++; if (bus.tx_rq !== 1'b0)    begin n_fail++; $display("FAIL mid_rq: got %b want 0", bus.tx_rq); end
      n_tests++; if (bus.grant !== 4'b0000) begin n_fail++; $display("FAIL mid_grant_clr: got %b want 0000", bus.grant); end
      n_tests++; if (bus.busy !== 1'b0)     begin n_fail++; $display("FAIL mid_busy: got %b want 0", bus.busy); end
      n_tests++; if (bus.tx_cycle !== 5'd0) begin n_fail++; $display("FAIL mid_cycle: got %0d want 0", bus.tx_cycle); end
      bus.req = 4'b1010;
      repeat (2) @(negedge clk);
      reset = 1'b1; model_en = 1'b1;
      wait_grant(10, ok);
      n_tests++; if (bus.grant !== 4'b0010) begin n_fail++; $display("FAIL mid_rearb: got %b want 0010", bus.grant); end
      wait_done(100, ok);
      n_tests++; if (bus.tx_cycle !== 5'd1) begin n_fail++; $display("FAIL mid_after_cycle: got %0d want 1", bus.tx_cycle); end
      @(negedge clk); bus.req = '0;
      wait_idle(30, ok);
   endtask

`ifdef UART_SCHED_WATCHDOG_EN
   task automatic test_watchdog();
      logic ok, seen_err;
      int   starts, dones;
      do_reset();
      model_len = 5;
      @(negedge clk); model_en = 1'b0; bus.req = 4'b0011;
      wait_grant(10, ok);
      n_tests++; if (bus.grant !== 4'b0001) begin n_fail++; $display("FAIL wd_grant: got %b want 0001", bus.grant); end
      starts = 1; dones = 0; seen_err = 1'b0;
      for (int i = 0; i < 200; i++) begin
         tick();
         if (bus.done != '0) dones++;
         if (bus.err) begin seen_err = 1'b1; break; end
         if (bus.tx_rq) starts++;
      end
      n_tests++; if (!seen_err)             begin n_fail++; $display("FAIL wd_err: got none want pulse"); end
      n_tests++; if (starts != 100)         begin n_fail++; $display("FAIL wd_start_cycles: got %0d want 100", starts); end
      n_tests++; if (dones != 0)            begin n_fail++; $display("FAIL wd_no_done: got %0d want 0", dones); end
      n_tests++; if (bus.tx_rq !== 1'b0)    begin n_fail++; $display("FAIL wd_rq: got %b want 0", bus.tx_rq); end
      n_tests++; if (bus.grant !== 4'b0000) begin n_fail++; $display("FAIL wd_grant_clr: got %b want 0000", bus.grant); end
      n_tests++; if (bus.tx_cycle !== 5'd0) begin n_fail++; $display("FAIL wd_cycle: got %0d want 0", bus.tx_cycle); end
      tick();
      n_tests++; if (bus.err !== 1'b0)      begin n_fail++; $display("FAIL wd_err_pulse: got %b want 0", bus.err); end
      @(negedge clk); model_en = 1'b1;
      wait_grant(30, ok);
      n_tests++; if (bus.grant !== 4'b0010) begin n_fail++; $display("FAIL wd_next_grant: got %b want 0010", bus.grant); end
      wait_done(100, ok);
      n_tests++; if (bus.tx_cycle !== 5'd1) begin n_fail++; $display("FAIL wd_next_cycle: got %0d want 1", bus.tx_cycle); end
      @(negedge clk); bus.req = '0;
      wait_idle(30, ok);
   endtask
`else
   task automatic test_no_watchdog();
      logic ok;
      int   errs, rq_low;
      do_reset();
      model_len = 5;
      @(negedge clk); model_en = 1'b0; bus.req = 4'b0001;
      wait_grant(10, ok);
      errs = 0; rq_low = 0;
      for (int i = 0; i < 300; i++) begin
         tick();
         if (bus.err) errs++;
         if (!bus.tx_rq) rq_low++;
      end
      n_tests++; if (errs != 0)             begin n_fail++; $display("FAIL nowd_err: got %0d want 0", errs); end
      n_tests++; if (rq_low != 0)           begin n_fail++; $display("FAIL nowd_rq_held: got %0d low want 0", rq_low); end
      n_tests++; if (bus.grant !== 4'b0001) begin n_fail++; $display("FAIL nowd_grant: got %b want 0001", bus.grant); end
      @(negedge clk); model_en = 1'b1;
      wait_done(50, ok);
      n_tests++; if (bus.done !== 4'b0001)  begin n_fail++; $display("FAIL nowd_done: got %b want 0001", bus.done); end
      @(negedge clk); bus.req = '0;
      wait_idle(30, ok);
   endtask
`endif

   initial begin
      n_tests = 0;
      n_fail  = 0;
      test_reset();
      test_single();
      test_round_robin();
      test_data_path();
      test_cycle_wrap();
      test_reset_midframe();
`ifdef UART_SCHED_WATCHDOG_EN
      test_watchdog();
`else
      test_no_watchdog();
`endif
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end
endmodule
